// File: rtl/trigger_capture_pkg.sv
// Shared types and helpers for the trigger window capture block.
package trigger_capture_pkg;

   // Capture sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_ARMED = 3'd2,
      ST_POST  = 3'd3,
      ST_DRAIN = 3'd4
   } state_e;

   // Threshold used when the programmed trigger level is zero.
   localparam int DEFAULT_TRIGGER_LEVEL = 5;

   // Effective trigger level: a programmed zero means "use the default".
   function automatic logic [31:0] eff_trigger_level(input logic [31:0] level);
      return (level == 32'd0) ? 32'(DEFAULT_TRIGGER_LEVEL) : level;
   endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample ring: one write port, one registered read port.
// The read register holds its value while re_i is low, so the owner can use
// it as a pipeline stage that stalls.
module capture_ram #(
   parameter  int DATA_WIDTH = 16,
   parameter  int DEPTH      = 1024,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Write port.
   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
   end

   // Registered read port, holds when not enabled.
   always_ff @(posedge clk_i) begin
      if (re_i) rdata_q <= mem[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/trigger_window_capture.sv
// Pre/post trigger window capture: samples stream into a ring buffer, a
// rising-edge threshold crossing fixes the window, and the window is then
// replayed in chronological order on an AXI4-Stream master.
module trigger_window_capture
   import trigger_capture_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 1024,
   parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_data_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [DATA_WIDTH-1:0] trigger_level,
   input  logic [CNT_WIDTH-1:0]  pre_samples,
   input  logic [CNT_WIDTH-1:0]  post_samples,
   input  logic                  arm,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  busy,
   output logic                  triggered,
   output logic [15:0]           dropped,
   output state_e                dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] ONE_C   = CNT_WIDTH'(1);

   state_e                state_q;
   logic [AW-1:0]         wr_ptr_q, rd_addr_q;
   logic [CNT_WIDTH-1:0]  pre_eff_q, post_eff_q, fill_cnt_q, post_cnt_q, rd_cnt_q;
   logic [DATA_WIDTH-1:0] prev_q;
   logic                  triggered_q;
   logic [15:0]           dropped_q;
   logic                  s1_v_q, s1_last_q;
   logic                  out_v_q, out_last_q;
   logic [DATA_WIDTH-1:0] out_data_q;

   logic [CNT_WIDTH-1:0]  post_eff_d, pre_eff_d, room, fill_d, total;
   logic [DATA_WIDTH-1:0] level_eff, ram_rdata;
   logic                  is_trig, wr_en, out_ready, rd_issue;

   // Latched counts on arm, trigger qualification, and read-issue credit.
   always_comb begin
      post_eff_d = (post_samples == '0) ? ONE_C :
                   ((post_samples > DEPTH_C) ? DEPTH_C : post_samples);
      room       = DEPTH_C - post_eff_d;
      pre_eff_d  = (pre_samples > room) ? room : pre_samples;
      level_eff  = DATA_WIDTH'(eff_trigger_level(32'(trigger_level)));
      fill_d     = fill_cnt_q + CNT_WIDTH'(in_data_valid);
      is_trig    = in_data_valid && (in_data >= level_eff) && (prev_q < level_eff);
      wr_en      = in_data_valid &&
                   (state_q == ST_FILL || state_q == ST_ARMED || state_q == ST_POST);
      total      = pre_eff_q + post_eff_q;
      out_ready  = !out_v_q || m_axis_tready;
      // A read may be issued only when the RAM output stage is empty or
      // is moving into the output register on this edge.
      rd_issue   = (state_q == ST_DRAIN) && (rd_cnt_q != total) &&
                   (!s1_v_q || out_ready);
   end

   // Capture sequencer with its registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_addr_q   <= '0;
         pre_eff_q   <= '0;
         post_eff_q  <= '0;
         fill_cnt_q  <= '0;
         post_cnt_q  <= '0;
         rd_cnt_q    <= '0;
         prev_q      <= '1;
         triggered_q <= 1'b0;
         dropped_q   <= '0;
      end else begin
         triggered_q <= 1'b0;
         if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
         case (state_q)
            ST_IDLE: begin
               if (arm) begin
                  pre_eff_q  <= pre_eff_d;
                  post_eff_q <= post_eff_d;
                  wr_ptr_q   <= '0;
                  fill_cnt_q <= '0;
                  post_cnt_q <= '0;
                  rd_cnt_q   <= '0;
                  prev_q     <= '1;
                  dropped_q  <= '0;
                  state_q    <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (in_data_valid) prev_q <= in_data;
               fill_cnt_q <= fill_d;
               if (fill_d >= pre_eff_q) state_q <= ST_ARMED;
            end
            ST_ARMED: begin
               if (in_data_valid) prev_q <= in_data;
               if (is_trig) begin
                  rd_addr_q   <= wr_ptr_q - AW'(pre_eff_q);
                  triggered_q <= 1'b1;
                  post_cnt_q  <= ONE_C;
                  state_q     <= (post_eff_q == ONE_C) ? ST_DRAIN : ST_POST;
               end
            end
            ST_POST: begin
               if (in_data_valid) begin
                  post_cnt_q <= post_cnt_q + ONE_C;
                  if ((post_cnt_q + ONE_C) == post_eff_q) state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (in_data_valid && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
               if (rd_issue) begin
                  rd_cnt_q  <= rd_cnt_q + ONE_C;
                  rd_addr_q <= rd_addr_q + AW'(1);
               end
               if (out_v_q && m_axis_tready && out_last_q) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Output pipeline: RAM read register (stage 1, holds while stalled) feeding
   // the output register. Stream handshake: a beat transfers on a rising edge
   // where tvalid and tready are both high; while tvalid is high and tready is
   // low, tdata/tvalid/tlast stay unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v_q     <= 1'b0;
         s1_last_q  <= 1'b0;
         out_v_q    <= 1'b0;
         out_last_q <= 1'b0;
         out_data_q <= '0;
      end else begin
         if (rd_issue) begin
            s1_v_q    <= 1'b1;
            s1_last_q <= (rd_cnt_q == (total - ONE_C));
         end else if (s1_v_q && out_ready) begin
            s1_v_q    <= 1'b0;
         end
         if (out_ready) begin
            out_v_q    <= s1_v_q;
            out_last_q <= s1_v_q && s1_last_q;
            if (s1_v_q) out_data_q <= ram_rdata;
         end
      end
   end

   capture_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
   ) u_ram (
      .clk_i  (clk),
      .we_i   (wr_en),
      .waddr_i(wr_ptr_q),
      .wdata_i(in_data),
      .re_i   (rd_issue),
      .raddr_i(rd_addr_q),
      .rdata_o(ram_rdata)
   );

   assign m_axis_tdata  = out_data_q;
   assign m_axis_tvalid = out_v_q;
   assign m_axis_tlast  = out_last_q;
   assign busy          = (state_q != ST_IDLE);
   assign triggered     = triggered_q;
   assign dropped       = dropped_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_trigger_window_capture.sv
// Bench for trigger_window_capture: drives sample streams, predicts the
// captured window from the stream it drove, and compares every output beat.
module tb_trigger_window_capture;
   import trigger_capture_pkg::*;

   localparam int DW    = 16;
   localparam int DEPTH = 16;
   localparam int CW    = 5;

   logic          clk, rst;
   logic          in_data_valid;
   logic [DW-1:0] in_data, trigger_level;
   logic [CW-1:0] pre_samples, post_samples;
   logic          arm;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
   logic          busy, triggered;
   logic [15:0]   dropped;
   state_e        dbg_state;

   trigger_window_capture #(
      .DATA_WIDTH(DW),
      .DEPTH     (DEPTH),
      .CNT_WIDTH (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data_valid(in_data_valid),
      .in_data      (in_data),
      .trigger_level(trigger_level),
      .pre_samples  (pre_samples),
      .post_samples (post_samples),
      .arm          (arm),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast (m_axis_tlast),
      .busy         (busy),
      .triggered    (triggered),
      .dropped      (dropped),
      .dbg_state    (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- check task ----------------
   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   logic [DW:0]   exp_q[$];   // {last, data}
   logic [DW-1:0] hist[$];
   int            m_phase;    // 0 idle, 1 fill, 2 armed, 3 post, 4 drain
   int            m_pre, m_post, m_fill, m_cnt, m_drop;
   logic [DW-1:0] m_prev;
   int            beats_rx;
   logic [DW-1:0] first_beat;
   int            ready_mode;

   task automatic model_arm(input int pre, input int post);
      m_post = (post == 0) ? 1 : ((post > DEPTH) ? DEPTH : post);
      m_pre  = (pre > DEPTH - m_post) ? DEPTH - m_post : pre;
      m_prev = '1;
      m_fill = 0;
      m_cnt  = 0;
      m_drop = 0;
      hist.delete();
      m_phase = 1;
   endtask

   task automatic model_step(input logic v, input logic [DW-1:0] d, output logic trig);
      logic [DW-1:0] lvl;
      lvl  = (trigger_level == '0) ? DW'(5) : trigger_level;
      trig = 1'b0;
      case (m_phase)
         1: begin
            if (v) begin
               hist.push_back(d);
               m_prev = d;
               m_fill++;
            end
            if (m_fill >= m_pre) m_phase = 2;
         end
         2: begin
            if (v) begin
               if (d >= lvl && m_prev < lvl) begin
                  trig = 1'b1;
                  for (int i = hist.size() - m_pre; i < hist.size(); i++)
                     exp_q.push_back({1'b0, hist[i]});
                  exp_q.push_back({(m_post == 1), d});
                  m_cnt   = 1;
                  m_phase = (m_post == 1) ? 4 : 3;
               end else begin
                  hist.push_back(d);
                  m_prev = d;
               end
            end
         end
         3: begin
            if (v) begin
               m_cnt++;
               exp_q.push_back({(m_cnt == m_post), d});
               if (m_cnt == m_post) m_phase = 4;
            end
         end
         4: begin
            if (v && m_drop < 65535) m_drop++;
         end
         default: ;
      endcase
   endtask

   // ---------------- driver tasks ----------------
   task automatic cyc(input logic v, input logic [DW-1:0] d);
      logic t;
      in_data_valid = v;
      in_data       = d;
      @(posedge clk);
      #1;
      model_step(v, d, t);
      check_val("triggered", 32'(triggered), 32'(t));
   endtask

   task automatic do_arm(input int pre, input int post, input int lvl);
      trigger_level = DW'(lvl);
      pre_samples   = CW'(pre);
      post_samples  = CW'(post);
      in_data_valid = 1'b0;
      arm           = 1'b1;
      @(posedge clk);
      #1;
      arm = 1'b0;
      model_arm(pre, post);
      beats_rx = 0;
      // Counts are latched on arm; disturb the inputs afterwards.
      pre_samples  = CW'($urandom_range(0, 31));
      post_samples = CW'($urandom_range(0, 31));
      check_val("busy_after_arm", 32'(busy), 32'd1);
      check_val("dropped_cleared", 32'(dropped), 32'd0);
   endtask

   // Ramp from 'start' until the model reaches DRAIN; returns next ramp value.
   task automatic ramp_to_drain(input int start, output int next);
      int v;
      v = start;
      for (int i = 0; i < 200 && m_phase != 4; i++) begin
         cyc(1'b1, DW'(v));
         v++;
      end
      check_val("reached_drain", 32'(m_phase), 32'd4);
      next = v;
   endtask

   // Feed three samples that must be dropped, then wait for drain to finish.
   task automatic drain_wait(input int exp_beats);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, DW'(16'hA5A0 + i));
         if (i == 1) check_val("tvalid_within_2", 32'(m_axis_tvalid), 32'd1);
      end
      for (int n = 0; n < 300 && busy; n++) cyc(1'b0, '0);
      check_val("drain_done", 32'(busy), 32'd0);
      check_val("beats_left", 32'(exp_q.size()), 32'd0);
      check_val("beats_rx", 32'(beats_rx), 32'(exp_beats));
      check_val("dropped", 32'(dropped), 32'(m_drop));
      check_val("tvalid_idle", 32'(m_axis_tvalid), 32'd0);
      m_phase = 0;
   endtask

   // ---------------- tready driver ----------------
   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1:       m_axis_tready = ~m_axis_tready;
            2:       m_axis_tready = 1'($urandom_range(0, 1));
            default: m_axis_tready = 1'b1;
         endcase
      end
   end

   // ---------------- output monitor ----------------
   initial begin
      logic        held;
      logic [31:0] held_val;
      logic [DW:0] e;
      held = 1'b0;
      held_val = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            held = 1'b0;
         end else begin
            if (held)
               check_val("stall_hold", {14'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata}, held_val);
            if (m_axis_tvalid && m_axis_tready) begin
               if (exp_q.size() == 0) begin
                  check_val("unexpected_beat", 32'(m_axis_tdata), 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  check_val("beat_data", 32'(m_axis_tdata), 32'(e[DW-1:0]));
                  check_val("beat_last", 32'(m_axis_tlast), 32'(e[DW]));
               end
               if (beats_rx == 0) first_beat = m_axis_tdata;
               beats_rx++;
               held = 1'b0;
            end else if (m_axis_tvalid) begin
               held     = 1'b1;
               held_val = {14'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata};
            end else begin
               held = 1'b0;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int nxt;
      rst           = 1'b1;
      arm           = 1'b0;
      in_data_valid = 1'b0;
      in_data       = '0;
      trigger_level = '0;
      pre_samples   = '0;
      post_samples  = '0;
      ready_mode    = 0;
      m_phase       = 0;
      beats_rx      = 0;
      first_beat    = '0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      check_val("rst_tlast", 32'(m_axis_tlast), 32'd0);
      check_val("rst_tdata", 32'(m_axis_tdata), 32'd0);
      check_val("rst_dropped", 32'(dropped), 32'd0);
      check_val("rst_triggered", 32'(triggered), 32'd0);
      check_val("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      rst = 1'b0;

      // 1: ramp, level 10, pre 4 post 4, tready high
      do_arm(4, 4, 10);
      ramp_to_drain(0, nxt);
      drain_wait(8);
      check_val("s1_first_beat", 32'(first_beat), 32'd6);

      // 2: same with tready toggling
      ready_mode = 1;
      do_arm(4, 4, 10);
      ramp_to_drain(0, nxt);
      drain_wait(8);
      check_val("s2_first_beat", 32'(first_beat), 32'd6);
      ready_mode = 0;

      // 3: input already high at arm must not trigger
      do_arm(2, 3, 50);
      for (int i = 0; i < 10; i++) cyc(1'b1, DW'(100));
      check_val("s3_still_armed", 32'(dbg_state), 32'(ST_ARMED));
      for (int i = 0; i < 3; i++) cyc(1'b1, DW'(20));
      for (int i = 0; i < 20 && m_phase != 4; i++) cyc(1'b1, DW'(60 + 10 * i));
      drain_wait(5);
      check_val("s3_first_beat", 32'(first_beat), 32'd20);

      // 4a: oversize counts clamp to post 16, pre 0
      do_arm(20, 30, 10);
      ramp_to_drain(0, nxt);
      drain_wait(16);
      check_val("s4a_first_beat", 32'(first_beat), 32'd10);

      // 4b: window wraps the ring
      do_arm(12, 4, 20);
      ramp_to_drain(0, nxt);
      drain_wait(16);
      check_val("s4b_first_beat", 32'(first_beat), 32'd8);

      // 5: level 0 means 5; arm during POST ignored
      do_arm(1, 3, 0);
      cyc(1'b1, DW'(3));
      cyc(1'b1, DW'(4));
      cyc(1'b1, DW'(5));
      check_val("s5_in_post", 32'(dbg_state), 32'(ST_POST));
      arm = 1'b1;
      cyc(1'b1, DW'(6));
      arm = 1'b0;
      cyc(1'b1, DW'(7));
      drain_wait(4);
      check_val("s5_first_beat", 32'(first_beat), 32'd4);

      // 6: reset during drain after three beats
      do_arm(4, 4, 10);
      ramp_to_drain(0, nxt);
      for (int n = 0; n < 60 && beats_rx < 3; n++) cyc(1'b0, '0);
      check_val("s6_three_beats", 32'(beats_rx), 32'd3);
      rst = 1'b1;
      #1;
      check_val("s6_tvalid", 32'(m_axis_tvalid), 32'd0);
      check_val("s6_busy", 32'(busy), 32'd0);
      check_val("s6_state", 32'(dbg_state), 32'(ST_IDLE));
      exp_q.delete();
      m_phase = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      do_arm(4, 4, 10);
      ramp_to_drain(0, nxt);
      drain_wait(8);
      check_val("s6_first_beat", 32'(first_beat), 32'd6);

      // 7: random samples, random valid and tready
      ready_mode = 2;
      do_arm(5, 6, 128);
      for (int i = 0; i < 300 && m_phase != 4; i++)
         cyc(1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)));
      for (int i = 0; i < 60 && m_phase != 4; i++)
         cyc(1'b1, (i % 2 == 1) ? DW'(200) : DW'(10));
      check_val("s7_reached_drain", 32'(m_phase), 32'd4);
      drain_wait(11);
      ready_mode = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
